// File: rtl/protobuf_pkg.sv
// Shared types and constants for the protobuf byte packer.
// The AXI read channel always issues single-beat, single-byte INCR reads.
package protobuf_pkg;

   localparam int unsigned AXI_ID_W   = 4;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_LEN_W  = 8;
   localparam int unsigned LEN_W      = 16;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned KEEP_W     = 4;
   localparam int unsigned LANE_W     = 2;

   localparam logic [AXI_LEN_W-1:0] AXI_LEN   = 8'h00;
   localparam logic [2:0]           AXI_SIZE  = 3'b000;
   localparam logic [1:0]           AXI_BURST = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_EMIT = 2'd3
   } state_e;

   // One packed output word as it appears on the stream.
   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } word_t;

endpackage

// File: rtl/protobuf_byte_packer_if.sv
// AXI4 read-address/read-data channels plus the packed word output stream.
// master = packer side, slave = memory/sink side.
interface protobuf_byte_packer_if;
   import protobuf_pkg::*;

   logic [AXI_ID_W-1:0]   axm_m0_arid;
   logic [AXI_ADDR_W-1:0] axm_m0_araddr;
   logic [AXI_LEN_W-1:0]  axm_m0_arlen;
   logic [2:0]            axm_m0_arsize;
   logic [1:0]            axm_m0_arburst;
   logic                  axm_m0_arvalid;
   logic                  axm_m0_arready;

   logic [AXI_ID_W-1:0]   axm_m0_rid;
   logic [AXI_DATA_W-1:0] axm_m0_rdata;
   logic                  axm_m0_rlast;
   logic                  axm_m0_rvalid;
   logic                  axm_m0_rready;

   logic [WORD_W-1:0]     out_data;
   logic [KEEP_W-1:0]     out_keep;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output axm_m0_arid, axm_m0_araddr, axm_m0_arlen, axm_m0_arsize, axm_m0_arburst, axm_m0_arvalid,
      input  axm_m0_arready,
      input  axm_m0_rid, axm_m0_rdata, axm_m0_rlast, axm_m0_rvalid,
      output axm_m0_rready,
      output out_data, out_keep, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  axm_m0_arid, axm_m0_araddr, axm_m0_arlen, axm_m0_arsize, axm_m0_arburst, axm_m0_arvalid,
      output axm_m0_arready,
      output axm_m0_rid, axm_m0_rdata, axm_m0_rlast, axm_m0_rvalid,
      input  axm_m0_rready,
      input  out_data, out_keep, out_last, out_valid,
      output out_ready
   );

endinterface

// File: rtl/byte_lane_packer.sv
// Packing datapath: drops each byte into the current lane of a 32-bit word,
// little-endian, tracking which lanes hold valid bytes.
module byte_lane_packer
   import protobuf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [7:0]        wr_byte,
   output logic [LANE_W-1:0] lane,
   output logic [WORD_W-1:0] word,
   output logic [KEEP_W-1:0] keep
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= '0;
         word <= '0;
         keep <= '0;
      end else if (clear) begin
         lane <= '0;
         word <= '0;
         keep <= '0;
      end else if (wr_en) begin
         word[lane*8 +: 8] <= wr_byte;
         keep[lane]        <= 1'b1;
         lane              <= lane + LANE_W'(1);
      end
   end

endmodule

// File: rtl/protobuf_byte_packer.sv
// Drains a message one byte per AXI read and emits little-endian packed
// 32-bit words with byte keeps; FSM and remaining-byte counter live here.
module protobuf_byte_packer
   import protobuf_pkg::*;
#(
   parameter logic [AXI_ID_W-1:0]   ARID    = 4'h0,
   parameter logic [AXI_ADDR_W-1:0] RD_ADDR = 32'h0000_0000
) (
   input  logic                  clock_clk,
   input  logic                  reset_reset_n,
   input  logic                  start,
   input  logic [LEN_W-1:0]      msg_len,
   output logic                  busy,
   output logic                  done,
   output logic                  id_err,
   protobuf_byte_packer_if.master bus
);

   logic [1:0]        rst_sync;
   logic              rst_n;
   state_e            state, state_n;
   logic [LEN_W-1:0]  cnt, cnt_n;
   logic              last_q, last_n;
   logic              id_err_n, done_n;
   logic              arvalid_q, rready_q, out_valid_q;
   logic              pk_clear, pk_wr;
   logic [LANE_W-1:0] lane;
   logic [WORD_W-1:0] word;
   logic [KEEP_W-1:0] keep;
   logic              unused_rd;

   // Async assert, synchronous release of the internal reset.
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) rst_sync <= '0;
      else                rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign bus.axm_m0_arid    = ARID;
   assign bus.axm_m0_araddr  = RD_ADDR;
   assign bus.axm_m0_arlen   = AXI_LEN;
   assign bus.axm_m0_arsize  = AXI_SIZE;
   assign bus.axm_m0_arburst = AXI_BURST;
   assign bus.axm_m0_arvalid = arvalid_q;
   assign bus.axm_m0_rready  = rready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_last       = last_q;
   assign bus.out_data       = word;
   assign bus.out_keep       = keep;

   // rlast is redundant with single-beat reads; upper data bytes carry no payload.
   assign unused_rd = ^{bus.axm_m0_rlast, bus.axm_m0_rdata[AXI_DATA_W-1:8]};

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      last_n   = last_q;
      id_err_n = id_err;
      done_n   = 1'b0;
      pk_clear = 1'b0;
      pk_wr    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               id_err_n = 1'b0;
               if (msg_len == LEN_W'(0)) begin
                  done_n = 1'b1;
               end else begin
                  cnt_n    = msg_len;
                  last_n   = 1'b0;
                  pk_clear = 1'b1;
                  state_n  = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (bus.axm_m0_arready) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (bus.axm_m0_rvalid) begin
               pk_wr = 1'b1;
               cnt_n = cnt - LEN_W'(1);
               if (bus.axm_m0_rid != ARID) id_err_n = 1'b1;
               if (lane == LANE_W'(3) || cnt == LEN_W'(1)) begin
                  last_n  = (cnt == LEN_W'(1));
                  state_n = ST_EMIT;
               end else begin
                  state_n = ST_ADDR;
               end
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
               pk_clear = 1'b1;
               last_n   = 1'b0;
               if (last_q) begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_ADDR;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Handshake valids are registered from the next state so they never
   // depend combinationally on the matching ready.
   always_ff @(posedge clock_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         last_q      <= 1'b0;
         id_err      <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         last_q      <= last_n;
         id_err      <= id_err_n;
         done        <= done_n;
         busy        <= (state_n != ST_IDLE);
         arvalid_q   <= (state_n == ST_ADDR);
         rready_q    <= (state_n == ST_DATA);
         out_valid_q <= (state_n == ST_EMIT);
      end
   end

   byte_lane_packer u_packer (
      .clk     (clock_clk),
      .rst_n   (rst_n),
      .clear   (pk_clear),
      .wr_en   (pk_wr),
      .wr_byte (bus.axm_m0_rdata[7:0]),
      .lane    (lane),
      .word    (word),
      .keep    (keep)
   );

endmodule

// File: tb/tb_protobuf_byte_packer.sv
// Scoreboard bench for protobuf_byte_packer: a byte-serving AXI slave and a
// stalling word sink run in the background; each test task checks its results.
module tb_protobuf_byte_packer;
   import protobuf_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] msg_len;
   logic        busy, done, id_err;

   protobuf_byte_packer_if bus ();

   protobuf_byte_packer #(.ARID(4'h0), .RD_ADDR(32'h0000_0000)) dut (
      .clock_clk     (clk),
      .reset_reset_n (rst_n),
      .start         (start),
      .msg_len       (msg_len),
      .busy          (busy),
      .done          (done),
      .id_err        (id_err),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] src_q[$];
   word_t      exp_q[$];
   word_t      obs_q[$];
   int         ar_stall = 0, out_stall = 0;
   int         ar_cnt = 0, r_cnt = 0, stable_err = 0;
   logic [3:0] rid_drive = 4'h0;

   // Background AXI slave + stream sink. Inputs change on negedge; handshakes
   // that happened at the previous posedge are resolved from the saved view.
   initial begin : slave
      bit    rd_pend, ar_seen, r_seen, ov_seen;
      word_t ov_word, cur;
      int    ar_wait, out_wait;
      rd_pend = 0; ar_seen = 0; r_seen = 0; ov_seen = 0; ov_word = '0;
      ar_wait = 0; out_wait = 0;
      bus.axm_m0_arready = 1'b0;
      bus.axm_m0_rvalid  = 1'b0;
      bus.axm_m0_rid     = 4'h0;
      bus.axm_m0_rdata   = '0;
      bus.axm_m0_rlast   = 1'b0;
      bus.out_ready      = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_pend = 0; ar_seen = 0; r_seen = 0; ov_seen = 0;
            ar_wait = 0; out_wait = 0;
            src_q.delete();
            obs_q.delete();
            bus.axm_m0_arready = 1'b0;
            bus.axm_m0_rvalid  = 1'b0;
            bus.out_ready      = 1'b0;
            continue;
         end
         if (ar_seen && bus.axm_m0_arready) begin rd_pend = 1; ar_cnt++; end
         if (r_seen && bus.axm_m0_rvalid) begin bus.axm_m0_rvalid = 1'b0; r_cnt++; end
         cur = '{data: bus.out_data, keep: bus.out_keep, last: bus.out_last};
         if (ov_seen) begin
            if (bus.out_ready) obs_q.push_back(ov_word);
            else if (!bus.out_valid || cur !== ov_word) stable_err++;
         end
         ar_seen = bus.axm_m0_arvalid;
         r_seen  = bus.axm_m0_rready;
         ov_seen = bus.out_valid;
         ov_word = cur;
         if (rd_pend && !bus.axm_m0_rvalid) begin
            bus.axm_m0_rdata  = {24'($urandom), (src_q.size() > 0) ? src_q.pop_front() : 8'hEE};
            bus.axm_m0_rid    = rid_drive;
            bus.axm_m0_rlast  = 1'($urandom);
            bus.axm_m0_rvalid = 1'b1;
            rd_pend = 0;
         end
         if (ar_seen && ar_wait >= ar_stall) begin bus.axm_m0_arready = 1'b1; ar_wait = 0; end
         else begin bus.axm_m0_arready = 1'b0; if (ar_seen) ar_wait++; end
         if (ov_seen && out_wait >= out_stall) begin bus.out_ready = 1'b1; out_wait = 0; end
         else begin bus.out_ready = 1'b0; if (ov_seen) out_wait++; end
      end
   end

   // Reference model: little-endian packing, 4 bytes per word, last on final.
   task automatic load_msg(input logic [7:0] bytes[$], input bit model);
      word_t w;
      int    n;
      n = bytes.size();
      w = '0;
      for (int i = 0; i < n; i++) begin
         src_q.push_back(bytes[i]);
         w.data[(i % 4) * 8 +: 8] = bytes[i];
         w.keep[i % 4] = 1'b1;
         if ((i % 4) == 3 || i == n - 1) begin
            w.last = (i == n - 1);
            if (model) exp_q.push_back(w);
            w = '0;
         end
      end
   endtask

   task automatic do_start(input logic [15:0] len);
      @(negedge clk);
      start   = 1'b1;
      msg_len = len;
      @(negedge clk);
      start   = 1'b0;
      msg_len = 16'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 0;
      #1;
      for (int i = 0; i < budget; i++) begin
         if (done) begin seen = 1; break; end
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic [79:0] out_snapshot();
      return {busy, done, id_err, bus.axm_m0_arvalid, bus.axm_m0_rready,
              bus.out_valid, bus.out_last, 37'(bus.out_keep), bus.out_data};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_snapshot() !== 80'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h exp 0", out_snapshot());
      end
      // start right at release must be swallowed by the reset synchronizer
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; msg_len = 16'd4;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_sync: busy=%b exp 0", busy); end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || ar_cnt !== 0) begin
         failures++; $display("FAIL reset_release_idle: busy=%b ar_cnt=%0d exp 0 0", busy, ar_cnt);
      end
   endtask

   task automatic test_single();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      int base;
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      base = ar_cnt;
      load_msg(b, 0);
      exp_q.push_back('{data: 32'h4433_2211, keep: 4'hF, last: 1'b1});
      do_start(16'd4);
      wait_done(300, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL single_done: timeout"); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_at_done: got %b exp 0", busy); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL single_count: got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL single_word: got %h exp %h", o, e); end
      end
      checks++;
      if (ar_cnt - base != 4) begin failures++; $display("FAIL single_reads: got %0d exp 4", ar_cnt - base); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_multi();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      load_msg(b, 0);
      exp_q.push_back('{data: 32'h0403_0201, keep: 4'hF, last: 1'b0});
      exp_q.push_back('{data: 32'h0000_0605, keep: 4'h3, last: 1'b1});
      do_start(16'd6);
      wait_done(400, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL multi_done: timeout"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL multi_count: got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL multi_word: got %h exp %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_zero();
      int base;
      base = ar_cnt;
      do_start(16'd0);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL zero_done: done=%b busy=%b exp 1 0", done, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: done=%b exp 0", done); end
      repeat (5) begin
         @(negedge clk); #1;
         checks++;
         if (bus.axm_m0_arvalid !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL zero_quiet: arvalid=%b out_valid=%b exp 0 0", bus.axm_m0_arvalid, bus.out_valid);
         end
      end
      checks++;
      if (ar_cnt != base || obs_q.size() != 0) begin
         failures++; $display("FAIL zero_no_traffic: reads=%0d words=%0d exp 0 0", ar_cnt - base, obs_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      int lens[4] = '{1, 2, 3, 5};
      foreach (lens[k]) begin
         b.delete();
         for (int i = 0; i < lens[k]; i++) b.push_back(8'($urandom));
         load_msg(b, 1);
         do_start(16'(lens[k]));
         wait_done(400, seen);
         checks++;
         if (!seen) begin failures++; $display("FAIL b2b_done len=%0d: timeout", lens[k]); end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL b2b_count: got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL b2b_word: got %h exp %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stall();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      int base;
      base = ar_cnt;
      stable_err = 0;
      ar_stall = 5; out_stall = 3;
      for (int i = 0; i < 7; i++) b.push_back(8'hA0 + 8'(i));
      load_msg(b, 1);
      do_start(16'd7);
      repeat (6) @(negedge clk);
      do_start(16'd2);  // must be ignored while busy
      wait_done(1000, seen);
      ar_stall = 0; out_stall = 0;
      checks++;
      if (!seen) begin failures++; $display("FAIL stall_done: timeout"); end
      checks++;
      if (stable_err != 0) begin failures++; $display("FAIL stall_stable: got %0d changes exp 0", stable_err); end
      checks++;
      if (ar_cnt - base != 7) begin failures++; $display("FAIL stall_reads: got %0d exp 7", ar_cnt - base); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL stall_count: got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL stall_word: got %h exp %h", o, e); end
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL stall_ignored_start: busy=%b exp 0", busy); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_id_err();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      rid_drive = 4'h5;
      b = '{8'h5A, 8'h6B, 8'h7C};
      load_msg(b, 1);
      do_start(16'd3);
      wait_done(300, seen);
      checks++;
      if (!seen || id_err !== 1'b1) begin
         failures++; $display("FAIL id_err_set: done_seen=%0d id_err=%b exp 1 1", seen, id_err);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (id_err !== 1'b1) begin failures++; $display("FAIL id_err_sticky: got %b exp 1", id_err); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL id_err_word: got %h exp %h", o, e); end
      end
      rid_drive = 4'h0;
      b = '{8'h01, 8'h02};
      load_msg(b, 1);
      do_start(16'd2);
      #1;
      checks++;
      if (id_err !== 1'b0) begin failures++; $display("FAIL id_err_clear: got %b exp 0", id_err); end
      wait_done(300, seen);
      checks++;
      if (!seen || id_err !== 1'b0) begin
         failures++; $display("FAIL id_err_clean_msg: done_seen=%0d id_err=%b exp 1 0", seen, id_err);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      word_t e, o;
      bit seen;
      int base;
      base = r_cnt;
      for (int i = 0; i < 8; i++) b.push_back(8'h80 + 8'(i));
      load_msg(b, 0);
      do_start(16'd8);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (r_cnt - base >= 2) begin seen = 1; break; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL midrst_progress: timeout"); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_snapshot() !== 80'h0) begin
         failures++; $display("FAIL midrst_outputs: got %h exp 0", out_snapshot());
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      load_msg(b, 0);
      exp_q.push_back('{data: 32'hC4C3_C2C1, keep: 4'hF, last: 1'b1});
      do_start(16'd4);
      wait_done(300, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL midrst_done: timeout"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++; $display("FAIL midrst_count: got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL midrst_word: got %h exp %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      msg_len = 16'd0;
      test_reset();
      test_single();
      test_multi();
      test_zero();
      test_back_to_back();
      test_stall();
      test_id_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
